// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and constants for the SRAM controller slice.
//   sram_state_t : controller FSM state encoding (also exported on the debug port)
//   reg_bus_t    : 32-bit CPU data / instruction bus word
//   CNT_W        : width of the wait-cycle counter (WAIT_CYCLES up to 15)
//   sel_to_be_n  : converts active-high byte selects to active-low SRAM enables
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      SramIdle = 2'd0,
      SramDAcc = 2'd1,
      SramIAcc = 2'd2,
      SramResp = 2'd3
   } sram_state_t;

   localparam int REG_BUS_W     = 32;
   localparam int SRAM_ADDR_DEF = 20;
   localparam int CNT_W         = 4;

   typedef logic [REG_BUS_W-1:0] reg_bus_t;

   function automatic logic [3:0] sel_to_be_n(input logic [3:0] sel);
      return ~sel;
   endfunction

endpackage

// File: rtl/sram_ifetch_buf.sv
// -----------------------------------------------------------------------------
// sram_ifetch_buf
// One-entry instruction-fetch buffer {valid, word address, instruction}.
// Only instantiated when SRAM_CTRL_IFETCH_BUF_EN is defined.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset (clears valid)
//   fill_en         : load the entry (completed SRAM fetch)
//   fill_addr/data  : word address and instruction to store
//   inv_en/inv_addr : data write entering the SRAM; clears valid on a match
//   lookup_addr     : current fetch word address
//   hit, hit_data   : valid entry matches lookup_addr, and its instruction
// -----------------------------------------------------------------------------
module sram_ifetch_buf
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill_en,
   input  logic [ADDR_W-1:0] fill_addr,
   input  reg_bus_t          fill_data,
   input  logic              inv_en,
   input  logic [ADDR_W-1:0] inv_addr,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit,
   output reg_bus_t          hit_data
);

   logic              valid_q;
   logic [ADDR_W-1:0] addr_q;
   reg_bus_t          data_q;

   // Fill and invalidate never coincide: fill happens at the end of a fetch,
   // invalidate when a data write leaves IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (fill_en) begin
         valid_q <= 1'b1;
         addr_q  <= fill_addr;
         data_q  <= fill_data;
      end else if (inv_en && (inv_addr == addr_q)) begin
         valid_q <= 1'b0;
      end
   end

   assign hit      = valid_q && (lookup_addr == addr_q);
   assign hit_data = data_q;

endmodule

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// Single-ported SRAM responder for the CPU data port (priority, with fairness)
// and the continuous instruction-fetch port. Each accepted access runs
// WAIT_CYCLES SRAM cycles and then pulses the issuing port's ready for one cycle.
// Optional feature: define SRAM_CTRL_IFETCH_BUF_EN to add a one-entry fetch
// buffer (sram_ifetch_buf) that answers repeated fetches without SRAM activity.
//
// Handshake: a port's request (ram_ce_i, or the implicit fetch) is sampled only
// in IDLE; once latched, the access always completes and its ready pulses once,
// even if the request drops. Initiators hold request inputs stable until ready.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   ram_ce_i/we_i/sel_i      : data request valid, write, byte enables
//   ram_addr_i, ram_data_i   : data byte address, write data
//   ram_data_o, ram_ready_o  : data read word, data completion pulse
//   pc_ram_i                 : fetch byte address
//   pc_ram_data_o/ready_o    : instruction word, fetch completion pulse
//   sram_addr_o, sram_data_o : SRAM word address, write data
//   sram_data_oe_o           : write-data pad driver enable
//   sram_data_i              : SRAM read data
//   sram_ce/oe/we_n_o        : active-low SRAM strobes
//   sram_be_n_o              : active-low SRAM byte enables
//   dbg_state_o              : current FSM state
// ADDR_W must be at most 29 (byte address bits [ADDR_W+1:2] are used).
// -----------------------------------------------------------------------------
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W      = SRAM_ADDR_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ram_ce_i,
   input  logic              ram_we_i,
   input  logic [3:0]        ram_sel_i,
   input  logic [31:0]       ram_addr_i,
   input  logic [31:0]       ram_data_i,
   output logic [31:0]       ram_data_o,
   output logic              ram_ready_o,
   input  logic [31:0]       pc_ram_i,
   output logic [31:0]       pc_ram_data_o,
   output logic              pc_ram_ready_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [31:0]       sram_data_o,
   output logic              sram_data_oe_o,
   input  logic [31:0]       sram_data_i,
   output logic              sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o,
   output logic [3:0]        sram_be_n_o,
   output sram_state_t       dbg_state_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   sram_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              last_cnt;
   logic              data_go;
   logic              buf_hit;

   logic              lat_we_q;
   logic [3:0]        lat_sel_q;
   logic [ADDR_W-1:0] lat_addr_q;
   reg_bus_t          lat_data_q;
   // Set when the access in flight (or just finished) belongs to the data port.
   // It steers ready in RESP and gives the fetch port the next IDLE slot.
   logic              last_data_q;
   reg_bus_t          ram_data_q;
   reg_bus_t          pc_data_q;

   logic [ADDR_W-1:0] data_word;
   logic [ADDR_W-1:0] pc_word;
   logic              unused_addr_bits;

   assign data_word = ram_addr_i[ADDR_W+1:2];
   assign pc_word   = pc_ram_i[ADDR_W+1:2];
   assign unused_addr_bits = ^{ram_addr_i[31:ADDR_W+2], ram_addr_i[1:0],
                               pc_ram_i[31:ADDR_W+2], pc_ram_i[1:0]};

   assign last_cnt = (cnt_q == CNT_LAST);
   // Fairness: a data request is only taken if the previous access was a fetch.
   assign data_go  = ram_ce_i && !last_data_q;

`ifdef SRAM_CTRL_IFETCH_BUF_EN
   reg_bus_t buf_data;

   sram_ifetch_buf #(
      .ADDR_W (ADDR_W)
   ) u_ifetch_buf (
      .clk         (clk),
      .rst         (rst),
      .fill_en     ((state_q == SramIAcc) && last_cnt),
      .fill_addr   (lat_addr_q),
      .fill_data   (sram_data_i),
      .inv_en      ((state_q == SramIdle) && data_go && ram_we_i),
      .inv_addr    (data_word),
      .lookup_addr (pc_word),
      .hit         (buf_hit),
      .hit_data    (buf_data)
   );
`else
   assign buf_hit = 1'b0;
`endif

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SramIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SramIdle: begin
            if (data_go) begin
               state_d = SramDAcc;
            end else if (buf_hit) begin
               state_d = SramResp;
            end else begin
               state_d = SramIAcc;
            end
         end
         SramDAcc, SramIAcc: begin
            if (last_cnt) begin
               state_d = SramResp;
            end
         end
         SramResp: state_d = SramIdle;
         default:  state_d = SramIdle;
      endcase
   end

   // ------------------------------------------------------ datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         lat_we_q    <= 1'b0;
         lat_sel_q   <= 4'h0;
         lat_addr_q  <= '0;
         lat_data_q  <= '0;
         last_data_q <= 1'b0;
         ram_data_q  <= '0;
         pc_data_q   <= '0;
      end else begin
         case (state_q)
            SramIdle: begin
               cnt_q <= '0;
               if (data_go) begin
                  lat_we_q    <= ram_we_i;
                  lat_sel_q   <= ram_sel_i;
                  lat_addr_q  <= data_word;
                  lat_data_q  <= ram_data_i;
                  last_data_q <= 1'b1;
               end else begin
                  // Fetches are always full-word reads; write data is left as is.
                  lat_we_q    <= 1'b0;
                  lat_addr_q  <= pc_word;
                  last_data_q <= 1'b0;
`ifdef SRAM_CTRL_IFETCH_BUF_EN
                  if (buf_hit) begin
                     pc_data_q <= buf_data;
                  end
`endif
               end
            end
            SramDAcc, SramIAcc: begin
               cnt_q <= cnt_q + 1'b1;
               if (last_cnt && !lat_we_q) begin
                  if (state_q == SramDAcc) begin
                     ram_data_q <= sram_data_i;
                  end else begin
                     pc_data_q <= sram_data_i;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------ outputs
   // Strobes are decoded from state so that reset releases them immediately.
   always_comb begin
      sram_ce_n_o    = 1'b1;
      sram_oe_n_o    = 1'b1;
      sram_we_n_o    = 1'b1;
      sram_be_n_o    = 4'hF;
      sram_data_oe_o = 1'b0;
      ram_ready_o    = 1'b0;
      pc_ram_ready_o = 1'b0;
      unique case (state_q)
         SramDAcc: begin
            sram_ce_n_o = 1'b0;
            sram_be_n_o = sel_to_be_n(lat_sel_q);
            if (lat_we_q) begin
               sram_data_oe_o = 1'b1;
               // Released on the last count to give address/data hold time.
               sram_we_n_o    = last_cnt;
            end else begin
               sram_oe_n_o = 1'b0;
            end
         end
         SramIAcc: begin
            sram_ce_n_o = 1'b0;
            sram_oe_n_o = 1'b0;
            sram_be_n_o = 4'h0;
         end
         SramResp: begin
            ram_ready_o    = last_data_q;
            pc_ram_ready_o = !last_data_q;
         end
         default: begin
         end
      endcase
   end

   assign sram_addr_o   = lat_addr_q;
   assign sram_data_o   = lat_data_q;
   assign ram_data_o    = ram_data_q;
   assign pc_ram_data_o = pc_data_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
// Directed bench for sram_ctrl with a small asynchronous SRAM model.
// Memory word i is initialised to 0xC0000000 | i while reset is low.
// Honours SRAM_CTRL_IFETCH_BUF_EN for the fetch-buffer sequence.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;
   import sram_ctrl_pkg::*;

`ifdef SRAM_CTRL_IFETCH_BUF_EN
   localparam int FETCH_AFTER_DATA_LAT = 1;
   localparam logic FETCH_AFTER_DATA_SRAM = 1'b0;
`else
   localparam int FETCH_AFTER_DATA_LAT = 3;
   localparam logic FETCH_AFTER_DATA_SRAM = 1'b1;
`endif

   // -------------------------------------------------------- clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        ram_ce_i, ram_we_i;
   logic [3:0]  ram_sel_i;
   logic [31:0] ram_addr_i, ram_data_i, ram_data_o;
   logic        ram_ready_o;
   logic [31:0] pc_ram_i, pc_ram_data_o;
   logic        pc_ram_ready_o;
   logic [19:0] sram_addr_o;
   logic [31:0] sram_data_o, sram_data_i;
   logic        sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
   logic [3:0]  sram_be_n_o;
   sram_state_t dbg_state_o;

   sram_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .ram_ce_i       (ram_ce_i),
      .ram_we_i       (ram_we_i),
      .ram_sel_i      (ram_sel_i),
      .ram_addr_i     (ram_addr_i),
      .ram_data_i     (ram_data_i),
      .ram_data_o     (ram_data_o),
      .ram_ready_o    (ram_ready_o),
      .pc_ram_i       (pc_ram_i),
      .pc_ram_data_o  (pc_ram_data_o),
      .pc_ram_ready_o (pc_ram_ready_o),
      .sram_addr_o    (sram_addr_o),
      .sram_data_o    (sram_data_o),
      .sram_data_oe_o (sram_data_oe_o),
      .sram_data_i    (sram_data_i),
      .sram_ce_n_o    (sram_ce_n_o),
      .sram_oe_n_o    (sram_oe_n_o),
      .sram_we_n_o    (sram_we_n_o),
      .sram_be_n_o    (sram_be_n_o),
      .dbg_state_o    (dbg_state_o)
   );

   // ------------------------------------------------------------ SRAM model
   logic [31:0] mem [0:255];

   assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[7:0]] : 32'h0;

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hC000_0000 | 32'(i);
      end else if (!sram_ce_n_o && !sram_we_n_o) begin
         for (int b = 0; b < 4; b++)
            if (!sram_be_n_o[b]) mem[sram_addr_o[7:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
      end
   end

   // ------------------------------------------------------------ scoreboard
   int total = 0;
   int bad   = 0;
   logic [0:0] exp_q[$];
   logic [0:0] got_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------ driver tasks
   task automatic wait_pc_ready();
      int n = 0;
      while (!pc_ram_ready_o && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!pc_ram_ready_o) chk("pc_ready_timeout", 32'(pc_ram_ready_o), 32'd1);
   endtask

   // Waits from the current negedge for the next fetch ready.
   task automatic fetch_step(input string tag, input logic [31:0] exp_data,
                             input int exp_lat, input logic exp_sram);
      int   lat = 0;
      logic saw = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (!sram_ce_n_o) saw = 1'b1;
      end while (!pc_ram_ready_o && lat < 30);
      chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
      chk({tag, "_data"}, pc_ram_data_o, exp_data);
      chk({tag, "_sram"}, 32'(saw), 32'(exp_sram));
   endtask

   // Issues one data access right after a fetch ready and checks it cycle by cycle.
   task automatic do_data(input string tag, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_rd);
      logic [19:0] exp_word;
      exp_word = addr[21:2];
      wait_pc_ready();
      ram_ce_i = 1'b1; ram_we_i = we; ram_sel_i = sel;
      ram_addr_i = addr; ram_data_i = wdata;
      @(negedge clk);  // IDLE
      chk({tag, "_idle_ce_n"}, 32'(sram_ce_n_o), 32'd1);
      @(negedge clk);  // ACC count 0
      chk({tag, "_acc0_ce_n"},    32'(sram_ce_n_o), 32'd0);
      chk({tag, "_acc0_addr"},    32'(sram_addr_o), 32'(exp_word));
      chk({tag, "_acc0_be_n"},    32'(sram_be_n_o), 32'(exp_be));
      chk({tag, "_acc0_we_n"},    32'(sram_we_n_o), 32'(!we));
      chk({tag, "_acc0_oe_n"},    32'(sram_oe_n_o), 32'(we));
      chk({tag, "_acc0_data_oe"}, 32'(sram_data_oe_o), 32'(we));
      if (we) chk({tag, "_acc0_wdata"}, sram_data_o, wdata);
      @(negedge clk);  // ACC count 1 (last)
      chk({tag, "_acc1_ce_n"},  32'(sram_ce_n_o), 32'd0);
      chk({tag, "_acc1_we_n"},  32'(sram_we_n_o), 32'd1);
      chk({tag, "_acc1_ready"}, 32'(ram_ready_o), 32'd0);
      @(negedge clk);  // RESP
      chk({tag, "_resp_ready"},    32'(ram_ready_o), 32'd1);
      chk({tag, "_resp_pc_ready"}, 32'(pc_ram_ready_o), 32'd0);
      chk({tag, "_resp_rdata"},    ram_data_o, exp_rd);
      chk({tag, "_resp_ce_n"},     32'(sram_ce_n_o), 32'd1);
      ram_ce_i = 1'b0;
      @(negedge clk);
      chk({tag, "_post_ready"}, 32'(ram_ready_o), 32'd0);
   endtask

   // ------------------------------------------------------------ watchdog
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ directed steps
   initial begin
      int pulses;
      int cyc;
      int n_ready;

      rst = 1'b0;
      ram_ce_i = 1'b0; ram_we_i = 1'b0; ram_sel_i = 4'h0;
      ram_addr_i = 32'h0; ram_data_i = 32'h0; pc_ram_i = 32'h0000_0100;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_ram_ready", 32'(ram_ready_o), 32'd0);
      chk("rst_pc_ready",  32'(pc_ram_ready_o), 32'd0);
      chk("rst_ram_data",  ram_data_o, 32'h0);
      chk("rst_pc_data",   pc_ram_data_o, 32'h0);
      chk("rst_ce_n",      32'(sram_ce_n_o), 32'd1);
      chk("rst_oe_n",      32'(sram_oe_n_o), 32'd1);
      chk("rst_we_n",      32'(sram_we_n_o), 32'd1);
      chk("rst_be_n",      32'(sram_be_n_o), 32'hF);
      chk("rst_data_oe",   32'(sram_data_oe_o), 32'd0);
      chk("rst_addr",      32'(sram_addr_o), 32'd0);
      chk("rst_wdata",     sram_data_o, 32'h0);
      chk("rst_state",     32'(dbg_state_o), 32'(SramIdle));
      rst = 1'b1;

      // First fetch after release: IDLE, two SRAM cycles, RESP
      fetch_step("fetch0", 32'hC000_0040, 3, 1'b1);

      // Reset in the middle of a write
      ram_ce_i = 1'b1; ram_we_i = 1'b1; ram_sel_i = 4'hF;
      ram_addr_i = 32'h20; ram_data_i = 32'h55AA_55AA;
      @(negedge clk);
      @(negedge clk);
      chk("midw_we_low", 32'(sram_we_n_o), 32'd0);
      #1 rst = 1'b0;
      #1;
      chk("midw_we_n",    32'(sram_we_n_o), 32'd1);
      chk("midw_ce_n",    32'(sram_ce_n_o), 32'd1);
      chk("midw_data_oe", 32'(sram_data_oe_o), 32'd0);
      chk("midw_ready",   32'(ram_ready_o), 32'd0);
      chk("midw_state",   32'(dbg_state_o), 32'(SramIdle));
      ram_ce_i = 1'b0;
      @(negedge clk);
      chk("midw_ready_held", 32'(ram_ready_o), 32'd0);
      rst = 1'b1;
      fetch_step("fetch_after_rst", 32'hC000_0040, 3, 1'b1);

      // Full write then read of 0x10
      do_data("wr10", 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 4'h0, 32'h0);
      do_data("rd10", 1'b0, 4'hF, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF);

      // Partial write over 0x11223344
      do_data("wr30",   1'b1, 4'hF,    32'h30, 32'h1122_3344, 4'h0,    32'hDEAD_BEEF);
      do_data("wr30b1", 1'b1, 4'b0010, 32'h30, 32'h0000_AB00, 4'b1101, 32'hDEAD_BEEF);
      do_data("rd30",   1'b0, 4'hF,    32'h30, 32'h0,         4'h0,    32'h1122_AB44);

      // Fetch following a data access
      fetch_step("fetch_after_data", 32'hC000_0040, FETCH_AFTER_DATA_LAT, FETCH_AFTER_DATA_SRAM);

      // Contention: data request held while fetch is continuous
      wait_pc_ready();
      ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_sel_i = 4'hF; ram_addr_i = 32'h10;
      exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
      got_q = {};
      pulses = 0;
      cyc = 0;
      while (pulses < 4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (ram_ready_o || pc_ram_ready_o) begin
            chk("cont_no_overlap", 32'(ram_ready_o && pc_ram_ready_o), 32'd0);
            got_q.push_back(ram_ready_o);
            pulses++;
         end
      end
      ram_ce_i = 1'b0;
      chk("cont_pulses", 32'(pulses), 32'd4);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         chk("cont_order", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      end
      chk("cont_rdata", ram_data_o, 32'hDEAD_BEEF);

      // Flush: request dropped during the read access
      wait_pc_ready();
      ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_sel_i = 4'hF; ram_addr_i = 32'h30;
      @(negedge clk);
      @(negedge clk);
      chk("flush_acc_ce_n", 32'(sram_ce_n_o), 32'd0);
      ram_ce_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("flush_ready", 32'(ram_ready_o), 32'd1);
      chk("flush_rdata", ram_data_o, 32'h1122_AB44);
      n_ready = 0;
      repeat (12) begin
         @(negedge clk);
         if (ram_ready_o) n_ready++;
      end
      chk("flush_no_extra", 32'(n_ready), 32'd0);

      // Repeated fetch of 0x100
      wait_pc_ready();
`ifdef SRAM_CTRL_IFETCH_BUF_EN
      pc_ram_i = 32'h0000_0104;
      fetch_step("buf_fetch104", 32'hC000_0041, 4, 1'b1);
      pc_ram_i = 32'h0000_0100;
      fetch_step("buf_miss100", 32'hC000_0040, 4, 1'b1);
      fetch_step("buf_hit100",  32'hC000_0040, 2, 1'b0);
      do_data("buf_wr100", 1'b1, 4'hF, 32'h100, 32'h0, 4'h0, 32'h1122_AB44);
      fetch_step("buf_inval100", 32'h0, 3, 1'b1);
`else
      fetch_step("refetch100_a", 32'hC000_0040, 4, 1'b1);
      fetch_step("refetch100_b", 32'hC000_0040, 4, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
